// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types and helpers for the LFSR scheduler.
//   state_t    - scheduler FSM states (IDLE, SHIFT, RESP)
//   TAP_MASK   - feedback taps of the 8-bit Fibonacci LFSR (bits 4,3,2,0)
//   lfsr_next  - one shift of the LFSR: {xor of taps, s[7:1]}
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [7:0] TAP_MASK = 8'h1D;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {^(s & TAP_MASK), s[7:1]};
  endfunction

endpackage

// File: rtl/lfsr8_core.sv
// lfsr8_core: 8-bit Fibonacci LFSR register.
//   clk   - rising-edge clock
//   rst   - asynchronous active-low reset, loads RESET_SEED
//   load  - load seed (priority over step)
//   seed  - value to load
//   step  - advance the LFSR by one shift
//   state - current LFSR contents
// Build option LFSR_ZERO_GUARD_EN: an all-zero seed (load or RESET_SEED)
// is replaced by 8'h01 so the register can never lock up at zero.
module lfsr8_core
  import lfsr_pkg::*;
#(
  parameter logic [7:0] RESET_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] state
);

`ifdef LFSR_ZERO_GUARD_EN
  localparam logic [7:0] RST_VAL = (RESET_SEED == 8'h00) ? 8'h01 : RESET_SEED;
  logic [7:0] seed_g;
  assign seed_g = (seed == 8'h00) ? 8'h01 : seed;
`else
  localparam logic [7:0] RST_VAL = RESET_SEED;
  logic [7:0] seed_g;
  assign seed_g = seed;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      state <= RST_VAL;
    else if (load) state <= seed_g;
    else if (step) state <= lfsr_next(state);
  end

endmodule

// File: rtl/lfsr_sched.sv
// lfsr_sched: round-robin scheduler sharing one 8-bit LFSR among N_REQ
// requesters. Each grant advances the LFSR STEPS times and returns the byte.
//   clk        - rising-edge clock
//   rst        - asynchronous active-low reset
//   seed       - seed value
//   seed_valid - seed load request (accepted only in IDLE, wins over req)
//   seed_ready - high while IDLE (combinational)
//   req        - per-requester level request, sampled in IDLE only
//   gnt        - one-hot grant pulse, one cycle
//   rdata      - random byte, valid with rvalid, held otherwise
//   rvalid     - response strobe (== |gnt)
//   busy       - high in SHIFT and RESP
// Build option LFSR_ZERO_GUARD_EN (applied in lfsr8_core): zero seeds map to 8'h01.
module lfsr_sched
  import lfsr_pkg::*;
#(
  parameter int         N_REQ      = 4,
  parameter int         STEPS      = 8,
  parameter logic [7:0] RESET_SEED = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       seed,
  input  logic             seed_valid,
  output logic             seed_ready,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [7:0]       rdata,
  output logic             rvalid,
  output logic             busy
);

  localparam int          IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int          CW = $clog2(STEPS + 1);
  localparam int unsigned NR = N_REQ;

  state_t         state, next_state;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  ptr, idx, win;
  logic           load, step;
  logic [7:0]     s;

  lfsr8_core #(.RESET_SEED(RESET_SEED)) u_core (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .seed  (seed),
    .step  (step),
    .state (s)
  );

  assign seed_ready = (state == IDLE);

  // Round-robin pick: walk upward from ptr+1 with wrap at N_REQ-1.
  always_comb begin : pick
    logic [IW-1:0] cand;
    logic          found;
    win   = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < NR; k++) begin
      cand = (cand == IW'(N_REQ - 1)) ? '0 : cand + IW'(1);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    unique case (state)
      IDLE: begin
        if (seed_valid)  load       = 1'b1;
        else if (|req)   next_state = SHIFT;
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt == CW'(1)) next_state = RESP;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      idx    <= '0;
      ptr    <= IW'(N_REQ - 1);
      gnt    <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
      busy   <= 1'b0;
    end else begin
      busy <= (next_state != IDLE);
      unique case (state)
        IDLE: begin
          if (next_state == SHIFT) begin
            idx <= win;
            cnt <= CW'(STEPS);
          end
        end
        SHIFT: begin
          cnt <= cnt - CW'(1);
          // Registered response is captured on the final shift edge, so the
          // byte is the core's post-shift value computed here in parallel.
          if (next_state == RESP) begin
            gnt    <= N_REQ'(1) << idx;
            rvalid <= 1'b1;
            rdata  <= lfsr_next(s);
          end
        end
        RESP: begin
          gnt    <= '0;
          rvalid <= 1'b0;
          ptr    <= idx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_sched.sv
module tb_lfsr_sched;
  localparam int         N_REQ      = 4;
  localparam int         STEPS      = 8;
  localparam logic [7:0] RESET_SEED = 8'hA5;

  logic             clk;
  logic             rst;
  logic [7:0]       seed;
  logic             seed_valid;
  logic             seed_ready;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [7:0]       rdata;
  logic             rvalid;
  logic             busy;

  lfsr_sched #(.N_REQ(N_REQ), .STEPS(STEPS), .RESET_SEED(RESET_SEED)) dut (
    .clk        (clk),
    .rst        (rst),
    .seed       (seed),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .req        (req),
    .gnt        (gnt),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int unsigned m_s;
  int          m_ptr;
  int unsigned m_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned ref_shift(input int unsigned v);
    int unsigned fb;
    fb = ((v >> 4) ^ (v >> 3) ^ (v >> 2) ^ v) & 1;
    return ((fb << 7) | (v >> 1)) & 32'hFF;
  endfunction

  function automatic int unsigned ref_guard(input int unsigned v);
`ifdef LFSR_ZERO_GUARD_EN
    return (v == 0) ? 1 : v;
`else
    return v;
`endif
  endfunction

  function automatic int ref_winner(input logic [N_REQ-1:0] pat);
    int i;
    for (int k = 1; k <= N_REQ; k++) begin
      i = (m_ptr + k) % N_REQ;
      if (pat[i]) return i;
    end
    return -1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called at a sample point in IDLE. Returns at the sample point of the
  // idle cycle that follows the response.
  task automatic serve(input logic [N_REQ-1:0] pat, input bit release_req, input bit noisy,
                       output logic [7:0] got_data, output int got_idx);
    int          w;
    int unsigned v;
    req = pat;
    w = ref_winner(pat);
    v = m_s;
    repeat (STEPS) v = ref_shift(v);
    tick;
    for (int c = 0; c < STEPS; c++) begin
      check("shift_busy", busy, 1);
      check("shift_no_gnt", {rvalid, gnt}, 0);
      check("shift_seed_stall", seed_ready, 0);
      if (noisy) begin
        req        = N_REQ'($urandom_range(0, (1 << N_REQ) - 1));
        seed_valid = 1'($urandom_range(0, 1));
        seed       = 8'($urandom);
      end
      tick;
    end
    check("resp_gnt", gnt, (w >= 0) ? (32'd1 << w) : 32'd0);
    check("resp_rvalid", rvalid, 1);
    check("resp_rdata", rdata, v);
    check("resp_busy", busy, 1);
    check("resp_seed_stall", seed_ready, 0);
    got_data = rdata;
    got_idx  = -1;
    for (int i = 0; i < N_REQ; i++) if (gnt[i]) got_idx = i;
    m_s        = v;
    m_ptr      = w;
    m_last     = v;
    seed_valid = 1'b0;
    req        = release_req ? '0 : pat;
    tick;
    check("idle_gnt", {rvalid, gnt}, 0);
    check("idle_busy", busy, 0);
    check("idle_seed_ready", seed_ready, 1);
    check("idle_rdata_hold", rdata, m_last);
  endtask

  task automatic do_seed(input logic [7:0] val, input logic [N_REQ-1:0] pat);
    check("seed_ready_idle", seed_ready, 1);
    seed       = val;
    seed_valid = 1'b1;
    req        = pat;
    tick;
    seed_valid = 1'b0;
    m_s        = ref_guard(val);
    check("seed_no_shift", busy, 0);
    check("seed_no_resp", rvalid, 0);
  endtask

  task automatic do_reset;
    req        = '0;
    seed_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_rdata", rdata, 0);
    check("rst_seed_ready", seed_ready, 1);
    m_s    = ref_guard(RESET_SEED);
    m_ptr  = N_REQ - 1;
    m_last = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    tick;
    check("post_rst_busy", busy, 0);
  endtask

  logic [7:0] d;
  int         gi;
  int         order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst        = 1'b1;
    seed       = '0;
    seed_valid = 1'b0;
    req        = '0;
    m_s        = 0;
    m_ptr      = N_REQ - 1;
    m_last     = 0;

    do_reset();

    // seed 01, held request: 71 then A4 with one idle cycle between
    do_seed(8'h01, '0);
    serve(4'b0001, 1'b0, 1'b0, d, gi);
    check("tp_first_byte", d, 8'h71);
    serve(4'b0001, 1'b1, 1'b0, d, gi);
    check("tp_second_byte", d, 8'hA4);

    // all requesting from reset: round-robin order
    do_reset();
    for (int n = 0; n < 5; n++) begin
      serve(4'b1111, 1'b0, 1'b0, d, gi);
      check("rr_order", gi, order[n]);
    end
    req = '0;

    // seed and request together: seed wins, request served next cycle
    do_seed(8'h3C, 4'b0100);
    serve(4'b0100, 1'b1, 1'b0, d, gi);

    // zero seed
    do_seed(8'h00, '0);
    serve(4'b0010, 1'b1, 1'b0, d, gi);
`ifdef LFSR_ZERO_GUARD_EN
    check("zero_seed_byte", d, 8'h71);
`else
    check("zero_seed_byte", d, 8'h00);
`endif

    // reset in the middle of SHIFT
    do_seed(8'h5A, '0);
    req = 4'b1000;
    repeat (3) tick;
    check("mid_shift_busy", busy, 1);
    do_reset();
    for (int c = 0; c < STEPS + 3; c++) begin
      check("no_gnt_after_rst", {rvalid, gnt}, 0);
      tick;
    end
    serve(4'b0001, 1'b1, 1'b0, d, gi);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        do_seed(8'($urandom_range(1, 255)), '0);
      end else begin
        serve(N_REQ'($urandom_range(1, (1 << N_REQ) - 1)), 1'($urandom_range(0, 1)), 1'b1, d, gi);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lfsr_sched.md
# lfsr_sched

Round-robin scheduler sharing one 8-bit Fibonacci LFSR among `N_REQ` requesters. Each granted request advances the LFSR by `STEPS` shifts and returns the resulting byte with a one-hot grant. A seed port reloads the generator between requests. The block sits between the random-number consumers and the LFSR datapath. It is the only agent allowed to shift or seed it.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `STEPS`, default 8: LFSR shifts per request, 1..255.
- `RESET_SEED`, default 8'hA5: LFSR state after reset.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `seed`  in  8  seed value.
- `seed_valid`  in  1  seed load request.
- `seed_ready`  out  1  seed accepted this cycle when high with `seed_valid`.
- `req`  in  `N_REQ`  per-requester request, level.
- `gnt`  out  `N_REQ`  one-hot grant, one-cycle pulse.
- `rdata`  out  8  random byte, valid with `rvalid`.
- `rvalid`  out  1  response strobe, equals `|gnt`.
- `busy`  out  1  high in SHIFT and RESP.

## Operation
- LFSR step:
  - newbit = s[4]^s[3]^s[2]^s[0].
  - s <= {newbit, s[7:1]}.
  - Exactly one step per SHIFT cycle; no steps in any other state.
- FSM states IDLE, SHIFT, RESP.
  - Reset enters IDLE.
  - IDLE → SHIFT on request win; SHIFT → RESP after `STEPS` cycles; RESP → IDLE always.
- IDLE:
  - `seed_ready` = 1 (combinational, state==IDLE).
  - `seed_valid` has priority over `req`. On a seed load, s <= seed and the FSM stays in IDLE; `req` is ignored that cycle.
  - Otherwise, if `|req`, the winner is the first asserted index searching upward from ptr+1, modulo `N_REQ`. The winner index is latched, the step counter loads `STEPS`, and the FSM moves to SHIFT.
- SHIFT: one step per cycle and counter decrements; on reaching 1 the FSM goes to RESP.
- RESP:
  - `gnt[idx]`=1, `rvalid`=1, `rdata`=s for exactly one cycle.
  - ptr <= idx.
- `req` is sampled only in IDLE. Deassertion during SHIFT/RESP does not abort service; the grant still fires. Requesters must hold `req` until they see `gnt`.
- `rdata` holds its last value outside RESP.
- Reset values: s=`RESET_SEED`, ptr=`N_REQ`-1 (so requester 0 wins first), `gnt`=0, `rvalid`=0, `rdata`=0, `busy`=0.
- Reset mid-operation aborts without any grant. The LFSR returns to `RESET_SEED`.

## Timing
- `req` high in IDLE at edge t: SHIFT occupies cycles t+1..t+`STEPS`; `gnt`/`rvalid` are high in cycle t+`STEPS`+1.
- Sustained throughput: one response per `STEPS`+2 cycles.
- A seed accepted at edge t is visible as s at t+1. The next request starts from the seeded value.
- A `seed_valid` asserted while busy is stalled (`seed_ready`=0) until IDLE.
- All outputs are registered except `seed_ready`.

## Configuration
- `LFSR_ZERO_GUARD_EN`:
  - Defined: a seed of 8'h00 loads 8'h01, and `RESET_SEED`=0 also resets to 8'h01. This prevents the all-zero lockup.
  - Undefined: seeds load verbatim. A zero state stays zero forever and every response returns 8'h00.

## Structure
- Package `lfsr_pkg`:
  - FSM state enum (IDLE/SHIFT/RESP).
  - Tap mask constant 8'h1D (bits 4,3,2,0).
  - Function `lfsr_next(s)` returning the next state.
- Sub-module `lfsr8_core`: the 8-bit register with `load`/`seed`/`step` inputs and `state` output, applying the zero guard.
- `lfsr_sched` owns the FSM, the step counter (width `$clog2(STEPS+1)`) and the round-robin pointer.

## Test plan
- Reset, then seed 8'h01, then `req`=4'b0001 (STEPS=8) → `gnt`=4'b0001 nine cycles after the request edge, `rdata`=8'h71.
- Same flow with `req` held → second response `rdata`=8'hA4. There is exactly one idle cycle between RESP and the next SHIFT.
- `req`=4'b1111 continuously from reset → grants in order 0,1,2,3,0; every grant is one-hot and one cycle long.
- `seed_valid` and `req` together in IDLE → seed loaded, `seed_ready`=1, no SHIFT that cycle. Request is serviced the following cycle from the new seed.
- Seed 8'h00 → with `LFSR_ZERO_GUARD_EN` the first byte is 8'h71; without it the first byte is 8'h00.
- `rst` low during SHIFT → `gnt`/`rvalid`/`busy` are 0 immediately, with no grant afterward. A fresh request after release returns the value derived from `RESET_SEED`.
